psr_stack_unit: RTL and testbench
=================================

# psr_stack_unit

Parametrised program-status unit for the armv4 core. It holds the CPSR (NZCV, IRQ/FIQ masks, 2-bit mode) plus a LIFO of saved PSR images, so exceptions can nest up to DEPTH deep. Each entry snapshots the CPSR, and each return restores the most recent snapshot. It sits beside the register file and is driven by the execute stage (flags, MSR/MRS) and the exception controller (entry and return).

## Interface
- DEPTH, 4, number of saved PSR images (≥1)
- DW, derived $clog2(DEPTH+1), width of the depth count
- clk  in  1  core clock
- rst  in  1  reset, synchronous, active-high; one clock
- en  in  1  stage enable; low freezes all state
- i_exc_req  in  1  exception entry this cycle
- i_exc_mode  in  2  target mode for entry (IRQ=1, FIQ=2, SVC=3)
- i_exc_ret  in  1  exception return: pop and restore
- i_nzcv_flag  in  1  ALU flag update strobe
- i_nzcv_alu  in  4  ALU NZCV result
- i_xpsr_en_ex  in  1  MSR write strobe
- i_xpsr_sel  in  1  0 = CPSR, 1 = SPSR (top of stack)
- i_xpsr_reg  in  32  MSR write data
- o_xpsr_reg  out  32  MRS read data, selected by i_xpsr_sel
- o_nzcv  out  4  registered flags
- o_nzcv_next  out  4  combinational next flags
- o_mode  out  2  current mode (USR=0)
- o_irq_mask, o_fiq_mask  out  1  current I and F
- o_depth  out  DW  saved-image count
- o_empty, o_full  out  1  depth==0 / depth==DEPTH
- o_ovf, o_unf  out  1  sticky overflow / underflow error flags

## Operation
- PSR image layout: [31:28] NZCV, [27:8] 0, [7] I, [6] F, [5:2] 0, [1:0] mode. Stored entries are 8 bits: {NZCV, I, F, mode}.
- Flag mux (o_nzcv_next):
  - MSR-to-CPSR data [31:28] takes priority.
  - Otherwise i_nzcv_alu when i_nzcv_flag is high.
  - Otherwise hold nzcv.
- CPSR MSR write:
  - Always updates NZCV.
  - Updates I, F and mode only when the current mode is not USR. In USR mode, control bits are silently ignored.
- SPSR MSR write:
  - Overwrites the top stack entry.
  - Ignored when o_empty.
- SPSR read when empty returns 32'h0.
- Entry (i_exc_req):
  - Push the post-update CPSR image: {nzcv_next, current I, F, mode, after any MSR this cycle}.
  - New mode = i_exc_mode; I = 1; F = 1 if the target is FIQ, else unchanged.
  - Entry control bits override any same-cycle CPSR MSR control bits.
  - When full: no push, depth unchanged, o_ovf set. The CPSR mode and mask update still happens.
  - i_exc_mode==USR is treated as SVC.
- Return (i_exc_ret):
  - CPSR ← top entry; depth decrements.
  - Overrides same-cycle flag update, CPSR MSR and SPSR MSR.
  - When empty: no change to CPSR or depth, o_unf set.
- If i_exc_req and i_exc_ret arrive together, entry wins and the return is dropped (no error).
- o_ovf and o_unf stay set until rst.

## Timing
- Reset values:
  - mode = SVC (3), I = 1, F = 1, nzcv = 0.
  - depth = 0, o_empty = 1, o_full = 0, o_ovf = 0, o_unf = 0.
  - Stack contents are don't-care; reads are gated by o_empty.
  - o_xpsr_reg = 32'h000000C3 with sel=0, and 0 with sel=1.
- All state updates on the rising clk edge when en=1, with 1-cycle latency.
- o_nzcv_next and o_xpsr_reg are combinational from current state and inputs.
- en=0: no state change, including the sticky flags. rst overrides en.
- Back-to-back entries and returns are supported every cycle.
- A push followed by a pop on the next cycle restores the image pushed.

## Structure
- Shared package psr_pkg holds:
  - Mode constants MODE_USR/IRQ/FIQ/SVC.
  - Bit-position localparams (PSR_N…PSR_V, PSR_I, PSR_F, PSR_MODE_LSB/MSB).
  - Packed struct psr_img_t {nzcv, i, f, mode}.
  - Pack/unpack functions converting psr_img_t to and from 32-bit words.
- Sub-module psr_lifo owns the storage and its control:
  - DEPTH×8-bit storage and the depth counter.
  - push, pop and top-write ports.
  - empty and full outputs.
- Top level keeps the CPSR registers, the priority logic and the sticky flags.

## Test plan
- Reset then MRS CPSR → 32'h000000C3; then MSR CPSR=32'h50000000 → mode=USR, I=F=0, nzcv=4'b0101.
- In USR mode, MSR CPSR=32'hF00000C3 → nzcv=4'hF, mode stays USR, I=F=0. In the same cycle, i_nzcv_flag with alu=4'h2 → MSR data wins, nzcv=4'hF.
- In USR mode with nzcv=4'h8, entry to IRQ → mode=1, I=1, depth=1. MRS SPSR → 32'h80000000. Then return → CPSR 32'h80000000, depth=0.
- DEPTH=4:
  - Five nested entries (IRQ,FIQ,SVC,IRQ,FIQ) → depth=4, o_full=1, o_ovf=1, mode=FIQ.
  - Four returns then pop to empty in order.
  - A fifth return → o_unf=1, CPSR unchanged.
- i_exc_req and i_exc_ret in the same cycle with depth=1 → depth=2, no o_unf or o_ovf.
- Return in the same cycle as i_nzcv_flag=1 → restored flags win.
- en=0 with i_exc_req=1 → no state change.
- rst asserted mid-nesting (depth=3) → next cycle depth=0, mode=SVC, o_ovf=o_unf=0.

Source files
------------

// File: rtl/psr_pkg.sv
// psr_pkg: shared definitions for the program-status unit.
// Holds the mode encodings, PSR bit positions, the compact 8-bit saved
// image type and helpers to convert it to and from a 32-bit PSR word.
package psr_pkg;

  localparam logic [1:0] MODE_USR = 2'd0;
  localparam logic [1:0] MODE_IRQ = 2'd1;
  localparam logic [1:0] MODE_FIQ = 2'd2;
  localparam logic [1:0] MODE_SVC = 2'd3;

  localparam int PSR_N        = 31;
  localparam int PSR_Z        = 30;
  localparam int PSR_C        = 29;
  localparam int PSR_V        = 28;
  localparam int PSR_I        = 7;
  localparam int PSR_F        = 6;
  localparam int PSR_MODE_MSB = 1;
  localparam int PSR_MODE_LSB = 0;

  typedef struct packed {
    logic [3:0] nzcv;
    logic       i;
    logic       f;
    logic [1:0] mode;
  } psr_img_t;

  // Reserved bits of the word read back as zero.
  function automatic logic [31:0] psr_pack(input psr_img_t p);
    logic [31:0] w;
    w                            = '0;
    w[PSR_N]                     = p.nzcv[3];
    w[PSR_Z]                     = p.nzcv[2];
    w[PSR_C]                     = p.nzcv[1];
    w[PSR_V]                     = p.nzcv[0];
    w[PSR_I]                     = p.i;
    w[PSR_F]                     = p.f;
    w[PSR_MODE_MSB:PSR_MODE_LSB] = p.mode;
    return w;
  endfunction

  function automatic psr_img_t psr_unpack(input logic [31:0] w);
    psr_img_t p;
    p.nzcv = {w[PSR_N], w[PSR_Z], w[PSR_C], w[PSR_V]};
    p.i    = w[PSR_I];
    p.f    = w[PSR_F];
    p.mode = w[PSR_MODE_MSB:PSR_MODE_LSB];
    return p;
  endfunction

endpackage

// File: rtl/psr_lifo.sv
// psr_lifo: DEPTH-entry stack of saved PSR images.
// Ports: clk_i/rst_i (sync, active-high)/en_i; push_i + push_img_i write a
// new entry; pop_i drops the top; wr_top_i + top_img_i overwrite the top.
// top_o is the current top entry (undefined when empty), depth_o the count,
// empty_o/full_o the boundary flags. The caller never pushes when full,
// never pops or writes the top when empty, and never pushes and pops together.
module psr_lifo
  import psr_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int DW    = $clog2(DEPTH + 1)
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          en_i,
  input  logic          push_i,
  input  logic          pop_i,
  input  logic          wr_top_i,
  input  psr_img_t      push_img_i,
  input  psr_img_t      top_img_i,
  output psr_img_t      top_o,
  output logic [DW-1:0] depth_o,
  output logic          empty_o,
  output logic          full_o
);

  psr_img_t      mem_q [DEPTH];
  logic [DW-1:0] depth_q, depth_d;

  always_comb begin
    depth_d = depth_q;
    if (push_i)     depth_d = depth_q + DW'(1);
    else if (pop_i) depth_d = depth_q - DW'(1);
  end

  always_ff @(posedge clk_i) begin
    if (rst_i)     depth_q <= '0;
    else if (en_i) depth_q <= depth_d;
  end

  // Entry k is written by a push when depth==k, or as the top when depth==k+1;
  // both can land in one cycle on different entries.
  always_ff @(posedge clk_i) begin
    if (en_i && !rst_i) begin
      for (int k = 0; k < DEPTH; k++) begin
        if (push_i && depth_q == DW'(k))
          mem_q[k] <= push_img_i;
        else if (wr_top_i && depth_q == DW'(k + 1))
          mem_q[k] <= top_img_i;
      end
    end
  end

  always_comb begin
    top_o = '0;
    for (int k = 0; k < DEPTH; k++)
      if (depth_q == DW'(k + 1)) top_o = mem_q[k];
  end

  assign depth_o = depth_q;
  assign empty_o = (depth_q == '0);
  assign full_o  = (depth_q == DW'(DEPTH));

endmodule

// File: rtl/psr_stack_unit.sv
// psr_stack_unit: CPSR plus a LIFO of saved PSR images for nested exceptions.
// Inputs: clk, rst (sync, active-high), en (freezes all state when low),
// exception entry/return requests, ALU flag update, MSR write (CPSR or SPSR).
// Outputs: MRS read data, registered and next flags, mode and masks, stack
// depth with empty/full, and sticky overflow/underflow flags.
module psr_stack_unit
  import psr_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int DW    = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          en,
  input  logic          i_exc_req,
  input  logic [1:0]    i_exc_mode,
  input  logic          i_exc_ret,
  input  logic          i_nzcv_flag,
  input  logic [3:0]    i_nzcv_alu,
  input  logic          i_xpsr_en_ex,
  input  logic          i_xpsr_sel,
  input  logic [31:0]   i_xpsr_reg,
  output logic [31:0]   o_xpsr_reg,
  output logic [3:0]    o_nzcv,
  output logic [3:0]    o_nzcv_next,
  output logic [1:0]    o_mode,
  output logic          o_irq_mask,
  output logic          o_fiq_mask,
  output logic [DW-1:0] o_depth,
  output logic          o_empty,
  output logic          o_full,
  output logic          o_ovf,
  output logic          o_unf
);

  psr_img_t   cpsr_q, cpsr_d;
  logic       ovf_q, ovf_d, unf_q, unf_d;
  psr_img_t   msr_img, ctl_img, top_img;
  logic       msr_cpsr, msr_spsr, ret_eff, push, pop, wr_top, empty, full;
  logic [1:0] tgt_mode;

  assign msr_img  = psr_unpack(i_xpsr_reg);
  assign msr_cpsr = i_xpsr_en_ex & ~i_xpsr_sel;
  assign msr_spsr = i_xpsr_en_ex &  i_xpsr_sel;
  // Entry wins over a simultaneous return; the return is simply dropped.
  assign ret_eff  = i_exc_ret & ~i_exc_req;
  assign tgt_mode = (i_exc_mode == MODE_USR) ? MODE_SVC : i_exc_mode;

  always_comb begin
    o_nzcv_next = cpsr_q.nzcv;
    if (msr_cpsr)         o_nzcv_next = msr_img.nzcv;
    else if (i_nzcv_flag) o_nzcv_next = i_nzcv_alu;
  end

  // CPSR after this cycle's flag/MSR update; this is also the image an entry saves.
  always_comb begin
    ctl_img      = cpsr_q;
    ctl_img.nzcv = o_nzcv_next;
    if (msr_cpsr && cpsr_q.mode != MODE_USR) begin
      ctl_img.i    = msr_img.i;
      ctl_img.f    = msr_img.f;
      ctl_img.mode = msr_img.mode;
    end
  end

  assign push   = i_exc_req & ~full;
  assign pop    = ret_eff & ~empty;
  assign wr_top = msr_spsr & ~ret_eff & ~empty;

  always_comb begin
    cpsr_d = ctl_img;
    ovf_d  = ovf_q | (i_exc_req & full);
    unf_d  = unf_q | (ret_eff & empty);
    if (i_exc_req) begin
      cpsr_d.mode = tgt_mode;
      cpsr_d.i    = 1'b1;
      if (tgt_mode == MODE_FIQ) cpsr_d.f = 1'b1;
    end else if (ret_eff) begin
      // A return on an empty stack leaves the CPSR untouched.
      cpsr_d = empty ? cpsr_q : top_img;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cpsr_q <= '{nzcv: 4'h0, i: 1'b1, f: 1'b1, mode: MODE_SVC};
      ovf_q  <= 1'b0;
      unf_q  <= 1'b0;
    end else if (en) begin
      cpsr_q <= cpsr_d;
      ovf_q  <= ovf_d;
      unf_q  <= unf_d;
    end
  end

  psr_lifo #(.DEPTH(DEPTH), .DW(DW)) u_lifo (
    .clk_i      (clk),
    .rst_i      (rst),
    .en_i       (en),
    .push_i     (push),
    .pop_i      (pop),
    .wr_top_i   (wr_top),
    .push_img_i (ctl_img),
    .top_img_i  (msr_img),
    .top_o      (top_img),
    .depth_o    (o_depth),
    .empty_o    (empty),
    .full_o     (full)
  );

  assign o_xpsr_reg = i_xpsr_sel ? (empty ? 32'h0 : psr_pack(top_img)) : psr_pack(cpsr_q);
  assign o_nzcv     = cpsr_q.nzcv;
  assign o_mode     = cpsr_q.mode;
  assign o_irq_mask = cpsr_q.i;
  assign o_fiq_mask = cpsr_q.f;
  assign o_empty    = empty;
  assign o_full     = full;
  assign o_ovf      = ovf_q;
  assign o_unf      = unf_q;

endmodule

// File: tb/tb_psr_stack_unit.sv
// tb_psr_stack_unit: scenario tasks push expected CPSR/depth/error state to a
// scoreboard as each cycle is driven and pop/compare it once the edge is taken.
module tb_psr_stack_unit;
  import psr_pkg::*;

  localparam int DEPTH = 4;
  localparam int DW    = $clog2(DEPTH + 1);
  localparam logic F0 = 1'b0;
  localparam logic T1 = 1'b1;

  logic          clk = 1'b0;
  logic          rst, en, i_exc_req, i_exc_ret, i_nzcv_flag, i_xpsr_en_ex, i_xpsr_sel;
  logic [1:0]    i_exc_mode;
  logic [3:0]    i_nzcv_alu;
  logic [31:0]   i_xpsr_reg;
  logic [31:0]   o_xpsr_reg;
  logic [3:0]    o_nzcv, o_nzcv_next;
  logic [1:0]    o_mode;
  logic          o_irq_mask, o_fiq_mask, o_empty, o_full, o_ovf, o_unf;
  logic [DW-1:0] o_depth;

  psr_stack_unit #(.DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .en(en), .i_exc_req(i_exc_req), .i_exc_mode(i_exc_mode),
    .i_exc_ret(i_exc_ret), .i_nzcv_flag(i_nzcv_flag), .i_nzcv_alu(i_nzcv_alu),
    .i_xpsr_en_ex(i_xpsr_en_ex), .i_xpsr_sel(i_xpsr_sel), .i_xpsr_reg(i_xpsr_reg),
    .o_xpsr_reg(o_xpsr_reg), .o_nzcv(o_nzcv), .o_nzcv_next(o_nzcv_next), .o_mode(o_mode),
    .o_irq_mask(o_irq_mask), .o_fiq_mask(o_fiq_mask), .o_depth(o_depth),
    .o_empty(o_empty), .o_full(o_full), .o_ovf(o_ovf), .o_unf(o_unf)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic          rst, en, req;
    logic [1:0]    m;
    logic          ret, flag;
    logic [3:0]    alu;
    logic          xen, sel;
    logic [31:0]   data;
    logic [31:0]   cpsr;
    logic [DW-1:0] depth;
    logic          ovf, unf;
  } row_t;

  row_t sb[$];
  row_t e;
  int   total = 0;
  int   bad   = 0;

  function automatic row_t mk(logic rst_v, logic en_v, logic req_v, logic [1:0] m_v,
                              logic ret_v, logic flag_v, logic [3:0] alu_v, logic xen_v,
                              logic sel_v, logic [31:0] data_v, logic [31:0] cpsr_v,
                              int d_v, logic ovf_v, logic unf_v);
    row_t r;
    r.rst = rst_v; r.en = en_v; r.req = req_v; r.m = m_v; r.ret = ret_v; r.flag = flag_v;
    r.alu = alu_v; r.xen = xen_v; r.sel = sel_v; r.data = data_v; r.cpsr = cpsr_v;
    r.depth = DW'(d_v); r.ovf = ovf_v; r.unf = unf_v;
    return r;
  endfunction

  task automatic idle();
    rst = 1'b0; en = 1'b1; i_exc_req = 1'b0; i_exc_mode = MODE_USR; i_exc_ret = 1'b0;
    i_nzcv_flag = 1'b0; i_nzcv_alu = 4'h0; i_xpsr_en_ex = 1'b0; i_xpsr_sel = 1'b0;
    i_xpsr_reg = 32'h0;
  endtask

  // Drive one cycle and record what the state must look like after the edge.
  task automatic apply(input row_t r);
    rst = r.rst; en = r.en; i_exc_req = r.req; i_exc_mode = r.m; i_exc_ret = r.ret;
    i_nzcv_flag = r.flag; i_nzcv_alu = r.alu; i_xpsr_en_ex = r.xen; i_xpsr_sel = r.sel;
    i_xpsr_reg = r.data;
    sb.push_back(r);
    @(posedge clk);
    #1;
    idle();
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    @(posedge clk);
    #1;
    idle();
    #1;
    total++;
    if (o_xpsr_reg !== 32'h000000C3) begin
      bad++; $display("FAIL reset_cpsr: got %h want 000000c3", o_xpsr_reg);
    end
    total++;
    if ({o_depth, o_empty, o_full, o_ovf, o_unf} !== {DW'(0), 4'b1000}) begin
      bad++; $display("FAIL reset_flags: got depth=%0d e=%b f=%b ovf=%b unf=%b want 0 1 0 0 0",
                      o_depth, o_empty, o_full, o_ovf, o_unf);
    end
    i_xpsr_sel = 1'b1; #1;
    total++;
    if (o_xpsr_reg !== 32'h0) begin
      bad++; $display("FAIL reset_spsr: got %h want 00000000", o_xpsr_reg);
    end
    i_xpsr_sel = 1'b0; #1;
  endtask

  task automatic test_msr();
    row_t rows[$];
    i_nzcv_flag = 1'b1; i_nzcv_alu = 4'h2; #1;
    total++;
    if (o_nzcv_next !== 4'h2) begin
      bad++; $display("FAIL nzcv_next_alu: got %h want 2", o_nzcv_next);
    end
    idle(); #1;
    apply(mk(F0, T1, F0, MODE_USR, F0, F0, 4'h0, T1, F0, 32'h50000000, 32'h50000000, 0, F0, F0));
    i_xpsr_en_ex = 1'b1; i_xpsr_reg = 32'hF00000C3; i_nzcv_flag = 1'b1; i_nzcv_alu = 4'h2; #1;
    total++;
    if (o_nzcv_next !== 4'hF) begin
      bad++; $display("FAIL nzcv_next_msr: got %h want f", o_nzcv_next);
    end
    rows.push_back(mk(F0, T1, F0, MODE_USR, F0, T1, 4'h2, T1, F0, 32'hF00000C3, 32'hF0000000, 0, F0, F0));
    rows.push_back(mk(F0, T1, F0, MODE_USR, F0, F0, 4'h0, T1, F0, 32'h80000000, 32'h80000000, 0, F0, F0));
    // The first row of this task was applied before the combinational probe.
    e = sb.pop_front();
    total++;
    if ({o_xpsr_reg, o_depth, o_ovf, o_unf} !== {e.cpsr, e.depth, e.ovf, e.unf} ||
        o_nzcv !== 4'h5 || o_mode !== MODE_USR) begin
      bad++; $display("FAIL msr step 0: got cpsr=%h nzcv=%h mode=%0d want cpsr=%h nzcv=5 mode=0",
                      o_xpsr_reg, o_nzcv, o_mode, e.cpsr);
    end
    foreach (rows[s]) begin
      apply(rows[s]);
      e = sb.pop_front();
      total++;
      if ({o_xpsr_reg, o_depth, o_ovf, o_unf} !== {e.cpsr, e.depth, e.ovf, e.unf} ||
          {o_nzcv, o_irq_mask, o_fiq_mask, o_mode} !== {e.cpsr[31:28], e.cpsr[7:6], e.cpsr[1:0]}) begin
        bad++; $display("FAIL msr step %0d: got cpsr=%h depth=%0d ovf=%b unf=%b want cpsr=%h depth=%0d ovf=%b unf=%b",
                        s + 1, o_xpsr_reg, o_depth, o_ovf, o_unf, e.cpsr, e.depth, e.ovf, e.unf);
      end
    end
    total++;
    if (o_nzcv_next !== 4'h8) begin
      bad++; $display("FAIL nzcv_next_hold: got %h want 8", o_nzcv_next);
    end
  endtask

  task automatic spsr_check(input string name, input logic [31:0] want);
    i_xpsr_sel = 1'b1; #1;
    total++;
    if (o_xpsr_reg !== want) begin
      bad++; $display("FAIL %s: got %h want %h", name, o_xpsr_reg, want);
    end
    i_xpsr_sel = 1'b0; #1;
  endtask

  task automatic test_entry_return();
    row_t rows[$];
    rows.push_back(mk(F0, T1, T1, MODE_IRQ, F0, F0, 4'h0, F0, F0, 32'h0, 32'h80000081, 1, F0, F0));
    rows.push_back(mk(F0, T1, F0, MODE_USR, F0, F0, 4'h0, T1, T1, 32'h200000C0, 32'h80000081, 1, F0, F0));
    rows.push_back(mk(F0, T1, F0, MODE_USR, F0, F0, 4'h0, T1, T1, 32'h80000000, 32'h80000081, 1, F0, F0));
    rows.push_back(mk(F0, T1, F0, MODE_USR, T1, F0, 4'h0, F0, F0, 32'h0, 32'h80000000, 0, F0, F0));
    foreach (rows[s]) begin
      apply(rows[s]);
      e = sb.pop_front();
      total++;
      if ({o_xpsr_reg, o_depth, o_ovf, o_unf} !== {e.cpsr, e.depth, e.ovf, e.unf} ||
          {o_empty, o_full} !== {e.depth == DW'(0), e.depth == DW'(DEPTH)}) begin
        bad++; $display("FAIL entry_ret step %0d: got cpsr=%h depth=%0d ovf=%b unf=%b want cpsr=%h depth=%0d ovf=%b unf=%b",
                        s, o_xpsr_reg, o_depth, o_ovf, o_unf, e.cpsr, e.depth, e.ovf, e.unf);
      end
      if (s == 0) spsr_check("spsr_after_entry", 32'h80000000);
      if (s == 1) spsr_check("spsr_after_write", 32'h200000C0);
      if (s == 3) spsr_check("spsr_when_empty", 32'h0);
    end
  endtask

  task automatic test_nesting();
    row_t rows[$];
    rows.push_back(mk(F0, T1, T1, MODE_IRQ, F0, F0, 4'h0, F0, F0, 32'h0, 32'h80000081, 1, F0, F0));
    rows.push_back(mk(F0, T1, T1, MODE_FIQ, F0, F0, 4'h0, F0, F0, 32'h0, 32'h800000C2, 2, F0, F0));
    rows.push_back(mk(F0, T1, T1, MODE_SVC, F0, F0, 4'h0, F0, F0, 32'h0, 32'h800000C3, 3, F0, F0));
    rows.push_back(mk(F0, T1, T1, MODE_IRQ, F0, F0, 4'h0, F0, F0, 32'h0, 32'h800000C1, 4, F0, F0));
    rows.push_back(mk(F0, T1, T1, MODE_FIQ, F0, F0, 4'h0, F0, F0, 32'h0, 32'h800000C2, 4, T1, F0));
    rows.push_back(mk(F0, T1, F0, MODE_USR, T1, F0, 4'h0, F0, F0, 32'h0, 32'h800000C3, 3, T1, F0));
    rows.push_back(mk(F0, T1, F0, MODE_USR, T1, F0, 4'h0, F0, F0, 32'h0, 32'h800000C2, 2, T1, F0));
    rows.push_back(mk(F0, T1, F0, MODE_USR, T1, F0, 4'h0, F0, F0, 32'h0, 32'h80000081, 1, T1, F0));
    rows.push_back(mk(F0, T1, F0, MODE_USR, T1, F0, 4'h0, F0, F0, 32'h0, 32'h80000000, 0, T1, F0));
    rows.push_back(mk(F0, T1, F0, MODE_USR, T1, F0, 4'h0, F0, F0, 32'h0, 32'h80000000, 0, T1, T1));
    foreach (rows[s]) begin
      apply(rows[s]);
      e = sb.pop_front();
      total++;
      if ({o_xpsr_reg, o_depth, o_ovf, o_unf} !== {e.cpsr, e.depth, e.ovf, e.unf} ||
          {o_empty, o_full} !== {e.depth == DW'(0), e.depth == DW'(DEPTH)} ||
          {o_irq_mask, o_fiq_mask, o_mode} !== {e.cpsr[7:6], e.cpsr[1:0]}) begin
        bad++; $display("FAIL nesting step %0d: got cpsr=%h depth=%0d full=%b ovf=%b unf=%b want cpsr=%h depth=%0d ovf=%b unf=%b",
                        s, o_xpsr_reg, o_depth, o_full, o_ovf, o_unf, e.cpsr, e.depth, e.ovf, e.unf);
      end
    end
  endtask

  // Reset, simultaneous entry/return, return vs flag update, en=0 freeze,
  // empty-stack return, USR target treated as SVC, and rst mid-nesting.
  task automatic test_back_to_back();
    row_t rows[$];
    rows.push_back(mk(T1, T1, F0, MODE_USR, F0, F0, 4'h0, F0, F0, 32'h0, 32'h000000C3, 0, F0, F0));
    rows.push_back(mk(F0, T1, T1, MODE_IRQ, F0, F0, 4'h0, F0, F0, 32'h0, 32'h000000C1, 1, F0, F0));
    rows.push_back(mk(F0, T1, T1, MODE_FIQ, T1, F0, 4'h0, F0, F0, 32'h0, 32'h000000C2, 2, F0, F0));
    rows.push_back(mk(F0, T1, F0, MODE_USR, T1, T1, 4'hF, F0, F0, 32'h0, 32'h000000C1, 1, F0, F0));
    rows.push_back(mk(F0, F0, T1, MODE_FIQ, F0, F0, 4'h0, F0, F0, 32'h0, 32'h000000C1, 1, F0, F0));
    rows.push_back(mk(F0, T1, F0, MODE_USR, T1, F0, 4'h0, F0, F0, 32'h0, 32'h000000C3, 0, F0, F0));
    rows.push_back(mk(F0, T1, F0, MODE_USR, T1, F0, 4'h0, F0, F0, 32'h0, 32'h000000C3, 0, F0, T1));
    rows.push_back(mk(F0, T1, T1, MODE_IRQ, F0, F0, 4'h0, F0, F0, 32'h0, 32'h000000C1, 1, F0, T1));
    rows.push_back(mk(F0, T1, T1, MODE_FIQ, F0, F0, 4'h0, F0, F0, 32'h0, 32'h000000C2, 2, F0, T1));
    rows.push_back(mk(F0, T1, T1, MODE_USR, F0, F0, 4'h0, F0, F0, 32'h0, 32'h000000C3, 3, F0, T1));
    rows.push_back(mk(T1, T1, T1, MODE_IRQ, F0, F0, 4'h0, F0, F0, 32'h0, 32'h000000C3, 0, F0, F0));
    foreach (rows[s]) begin
      apply(rows[s]);
      e = sb.pop_front();
      total++;
      if ({o_xpsr_reg, o_depth, o_ovf, o_unf} !== {e.cpsr, e.depth, e.ovf, e.unf} ||
          {o_empty, o_full} !== {e.depth == DW'(0), e.depth == DW'(DEPTH)}) begin
        bad++; $display("FAIL back_to_back step %0d: got cpsr=%h depth=%0d ovf=%b unf=%b want cpsr=%h depth=%0d ovf=%b unf=%b",
                        s, o_xpsr_reg, o_depth, o_ovf, o_unf, e.cpsr, e.depth, e.ovf, e.unf);
      end
    end
  endtask

  initial begin
    idle();
    rst = 1'b1;
    test_reset();
    test_msr();
    test_entry_return();
    test_nesting();
    test_back_to_back();
    total++;
    if (sb.size() != 0) begin
      bad++; $display("FAIL scoreboard_drain: got %0d left want 0", sb.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
